mux4x1_arbiter: RTL and testbench
=================================

# mux4x1_arbiter

Round-robin arbiter that shares one 4:1 single-bit mux among four requesters. Each requester raises `req[i]` to claim the mux; the block registers a one-hot grant, drives the mux select, and forwards the granted requester's data bit to `out`. A hold counter bounds how long one requester keeps the mux under contention. It sits between the requester logic and the shared output path as the mux's only controller.

## Interface
- `MAX_HOLD`, default 4: max consecutive grant cycles while another requester waits; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request per requester; level-sensitive, held while the mux is wanted.
- `in`  in  4  data bit per requester; `in[i]` belongs to requester i.
- `grant`  out  4  registered one-hot grant; 4'b0000 when idle.
- `sel`  out  2  registered mux select, the encoded index of `grant`.
- `gnt_valid`  out  1  registered; 1 when `grant` is non-zero.
- `out`  out  1  combinational `in[sel] & gnt_valid`.

## Operation
- Registered state: `state` (IDLE, GRANT), `cur[1:0]` (owner), `ptr[1:0]` (round-robin start), `hold_cnt[3:0]`.
- Next-owner search: the first index with `req` set, scanning `ptr, ptr+1, ptr+2, ptr+3` mod 4. When switching away from `cur`, scan starts at `cur+1` and excludes `cur`.
- IDLE:
  - `req==0` → stay in IDLE.
  - Otherwise grant the search winner, go to GRANT, `hold_cnt=1`.
- GRANT:
  - Owner drops `req[cur]`, others requesting → grant the next requester after `cur` on the same edge. No idle bubble; `gnt_valid` stays 1.
  - Owner drops, none requesting → IDLE; grant, `sel`, and `gnt_valid` go to 0.
  - Owner holds, `hold_cnt==MAX_HOLD`, another requester pending → switch to the next requester after `cur`, `hold_cnt=1`.
  - Owner holds, no other requester → keep grant; `hold_cnt` saturates at `MAX_HOLD`.
  - Otherwise → keep grant, `hold_cnt+1`.
- Every new grant to index k sets `ptr=k+1` mod 4; 3+1 wraps to 0.
- `sel` equals `cur` while `gnt_valid=1` and is 0 while idle.
- `grant` is always one-hot or zero; it is never multi-hot.

## Timing
- Reset: on any edge with `rst=1` → `state=IDLE`, `grant=0`, `sel=0`, `gnt_valid=0`, `ptr=0`, `hold_cnt=0`. `out` is therefore 0.
- Reset applied mid-grant drops the grant on that edge. Reset takes priority over all requests.
- Latency: `req` sampled high at edge N with the mux idle → `grant` visible after edge N. `out` follows `in` combinationally in the same cycle.
- Release: `req[cur]` low at edge N → owner loses grant at edge N.
- Simultaneous requests are resolved only by `ptr` order; there is no fixed priority.
- Requests that rise and fall between edges are not seen.

## Structure
- Package `mux4x1_arb_pkg` holds:
  - `NUM_REQ=4`
  - `SEL_W=2`
  - `HOLD_W=4`
  - state enum `arb_state_t {IDLE, GRANT}`
  - a function `rr_pick(req, start, exclude)` returning the index plus a found flag.
- Sub-module: the team's existing `mux4x1` (ports `in[3:0]`, `sel[1:0]`, `out`), instantiated for the data path. Its output is ANDed with `gnt_valid` at top level.
- The arbiter FSM, pointer, and counter live in the top module.

## Test plan
- Reset: `rst=1` for 3 cycles with `req=4'b1111` → `grant=0`, `gnt_valid=0`, `out=0`. On the first edge after release → `grant=4'b0001`, `sel=0`.
- Lone holder: `MAX_HOLD=4`, `req=4'b0100` held 10 cycles → `grant=4'b0100`, `sel=2` every cycle, no rotation, `hold_cnt` saturates at 4.
- Full contention: `MAX_HOLD=4`, `req=4'b1111` constant → `0001`×4, `0010`×4, `0100`×4, `1000`×4, then wrap to `0001`.
- Early release without bubble:
  - Owner 0 drops `req[0]` while `req=4'b0100` → next cycle `grant=4'b0100`, `gnt_valid` never 0.
  - Then `req=0` → IDLE, `grant=0`.
- Pointer wrap: last grant to 3, then `req=4'b1001` → `grant=4'b0001`. Reset asserted mid-grant → `grant=0` on that edge.
- Data path with `grant=4'b0010`:
  - `in=4'b0010` → `out=1`.
  - `in=4'b1101` → `out=0`.
  - Idle with `in=4'b1111` → `out=0`.

Source files
------------

// File: rtl/mux4x1_arbiter_pkg.sv
// Shared types and the round-robin search used by the 4-requester mux arbiter.
// rr_pick returns the first requester found scanning forward from a start index.
package mux4x1_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Scans start, start+1, ... (mod NUM_REQ); lowest offset wins, masked bits are skipped.
  function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                       input logic [SEL_W-1:0]   start,
                                       input logic [NUM_REQ-1:0] exclude);
    rr_pick_t         res;
    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0] idx;
    res  = '0;
    cand = req & ~exclude;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (cand[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4x1.sv
// Plain 4:1 single-bit multiplexer for the shared output path.
module mux4x1 (
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);

  assign out = in[sel];

endmodule

// File: rtl/mux4x1_arbiter.sv
// Round-robin arbiter owning one shared 4:1 mux; registered one-hot grant and select,
// with a hold counter bounding how long one owner keeps the mux under contention.
module mux4x1_arbiter
  import mux4x1_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] in,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               gnt_valid,
  output logic               out
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  arb_state_t         state_reg, state_next;
  logic [SEL_W-1:0]   cur_reg, cur_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic               gnt_valid_reg, gnt_valid_next;
  logic               new_grant;
  rr_pick_t           idle_pick, other_pick;
  logic               mux_out;

  assign idle_pick  = rr_pick(req, ptr_reg, '0);
  assign other_pick = rr_pick(req, cur_reg + SEL_W'(1), NUM_REQ'(1) << cur_reg);

  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    hold_cnt_next = hold_cnt_reg;
    new_grant     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (idle_pick.found) begin
          state_next    = GRANT;
          cur_next      = idle_pick.idx;
          hold_cnt_next = HOLD_W'(1);
          new_grant     = 1'b1;
        end
      end
      GRANT: begin
        if (!req[cur_reg]) begin
          // Owner released: hand over on the same edge, or go idle if nobody waits.
          if (other_pick.found) begin
            cur_next      = other_pick.idx;
            hold_cnt_next = HOLD_W'(1);
            new_grant     = 1'b1;
          end else begin
            state_next    = IDLE;
            cur_next      = '0;
            hold_cnt_next = '0;
          end
        end else if (hold_cnt_reg >= MAX_HOLD_C) begin
          // Saturated: rotate only if someone else is waiting.
          if (other_pick.found) begin
            cur_next      = other_pick.idx;
            hold_cnt_next = HOLD_W'(1);
            new_grant     = 1'b1;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        cur_next      = '0;
        hold_cnt_next = '0;
      end
    endcase
  end

  assign ptr_next       = new_grant ? cur_next + SEL_W'(1) : ptr_reg;
  assign gnt_valid_next = (state_next == GRANT);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_dec
    assign grant_next[gi] = gnt_valid_next && (cur_next == SEL_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_reg       <= '0;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
      grant_reg     <= '0;
      gnt_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_reg       <= cur_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
      grant_reg     <= grant_next;
      gnt_valid_reg <= gnt_valid_next;
    end
  end

  mux4x1 u_mux (
    .in  (in),
    .sel (cur_reg),
    .out (mux_out)
  );

  assign grant     = grant_reg;
  assign sel       = cur_reg;
  assign gnt_valid = gnt_valid_reg;
  assign out       = mux_out & gnt_valid_reg;

endmodule

// File: tb/tb_mux4x1_arbiter.sv
// Directed, table-driven check of the round-robin mux arbiter plus hand-written
// sequences for combinational data-path behaviour.
module tb_mux4x1_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] in  = '0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       gnt_valid;
  logic       out;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] g;
  } vec_t;

  vec_t vecs[$];

  mux4x1_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in        (in),
    .grant     (grant),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] di,
                     input logic [3:0] g);
    vec_t v;
    v.rst = r;
    v.req = rq;
    v.din = di;
    v.g   = g;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
    else
      pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    logic       exp_v;
    logic       exp_o;

    // Reset held with all requesting; data all ones so an ungated out would show.
    for (int k = 0; k < 3; k++) add(1'b1, 4'b1111, 4'b1111, 4'b0000);
    // Full contention: four cycles per owner, then wrap to requester 0.
    for (int k = 0; k < 17; k++) add(1'b0, 4'b1111, 4'b1111, 4'b0001 << ((k / 4) % 4));
    // Owner 0 drops while 2 waits: immediate handover, then idle.
    add(1'b0, 4'b0100, 4'b0100, 4'b0100);
    add(1'b0, 4'b0000, 4'b0100, 4'b0000);
    // Lone holder keeps the mux, counter saturates.
    for (int k = 0; k < 10; k++) add(1'b0, 4'b0100, 4'b1011, 4'b0100);
    // Saturated owner yields at once when someone else shows up.
    add(1'b0, 4'b0110, 4'b0010, 4'b0010);
    add(1'b0, 4'b1000, 4'b1000, 4'b1000);
    for (int k = 0; k < 3; k++) add(1'b0, 4'b1001, 4'b0111, 4'b1000);
    add(1'b0, 4'b1001, 4'b0001, 4'b0001);
    add(1'b0, 4'b0000, 4'b1111, 4'b0000);
    add(1'b0, 4'b1001, 4'b1000, 4'b1000);
    // Reset mid-grant drops the grant; pointer returns to 0.
    add(1'b1, 4'b1001, 4'b1111, 4'b0000);
    add(1'b0, 4'b1001, 4'b0001, 4'b0001);
    // Data path through requester 1.
    add(1'b0, 4'b0010, 4'b0010, 4'b0010);
    add(1'b0, 4'b0010, 4'b1101, 4'b0010);
    add(1'b0, 4'b0000, 4'b1111, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      in  = vecs[i].din;
      @(posedge clk);
      #1;
      exp_g = vecs[i].g;
      exp_s = enc(exp_g);
      exp_v = (exp_g != 4'b0000);
      exp_o = exp_v & vecs[i].din[exp_s];
      $display("step %0d rst=%b req=%b in=%b -> grant=%b sel=%0d valid=%b out=%b",
               i, rst, req, in, grant, sel, gnt_valid, out);
      chk("grant", i, grant, exp_g);
      chk("sel", i, {2'b00, sel}, {2'b00, exp_s});
      chk("gnt_valid", i, {3'b000, gnt_valid}, {3'b000, exp_v});
      chk("out", i, {3'b000, out}, {3'b000, exp_o});
    end

    // Combinational data path while requester 1 owns the mux.
    req = 4'b0010;
    in  = 4'b0000;
    @(posedge clk);
    #1;
    chk("seq_grant", 100, grant, 4'b0010);
    chk("seq_out_in0000", 101, {3'b000, out}, 4'b0000);
    in = 4'b0010;
    #1;
    chk("seq_out_in0010", 102, {3'b000, out}, 4'b0001);
    $display("seq in=%b grant=%b out=%b", in, grant, out);
    in = 4'b1101;
    #1;
    chk("seq_out_in1101", 103, {3'b000, out}, 4'b0000);
    in = 4'b0010;
    #1;
    chk("seq_out_back", 104, {3'b000, out}, 4'b0001);
    // Release to idle; data all ones must not leak.
    req = 4'b0000;
    in  = 4'b1111;
    @(posedge clk);
    #1;
    chk("seq_idle_grant", 105, grant, 4'b0000);
    chk("seq_idle_out", 106, {3'b000, out}, 4'b0000);
    $display("seq idle in=%b grant=%b out=%b", in, grant, out);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
